alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width (legal 8..64).
REQ-002 SHALL have parameter TAG_W, default 4, width of the transaction tag carried in-order through the block.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have ports in_valid input 1, in_ready output 1  request handshake.
REQ-006 SHALL have ports in_op input 4 (opcode), in_a input WIDTH, in_b input WIDTH, in_tag input TAG_W.
REQ-007 SHALL have ports out_valid output 1, out_ready input 1  response handshake.
REQ-008 SHALL have outputs out_y WIDTH (result), out_z, out_n, out_c, out_v 1 each (flags), out_err 1 (illegal opcode), out_tag TAG_W.

Function
REQ-009 Opcodes SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 MUL (low WIDTH bits of unsigned product); 11..15 illegal.
REQ-010 ADD: C = carry out of bit WIDTH-1; V = operands same sign and result sign differs.
REQ-011 SUB: y = a-b mod 2^WIDTH; C = borrow (1 iff a < b unsigned); V = operand signs differ and result sign differs from a.
REQ-012 All other ops SHALL set C=0, V=0; SLT/SLTU yield 1 or 0.
REQ-013 Shifts SHALL use shift amount b[$clog2(WIDTH)-1:0] only; upper bits of b ignored; SRA fills with a[WIDTH-1].
REQ-014 For every op, Z = (y==0), N = y[WIDTH-1].
REQ-015 Illegal opcode SHALL return y=0, Z=1, N=C=V=0, out_err=1; out_err=0 for legal ops.
REQ-016 Transfer occurs on a cycle where valid and ready are both 1; out_* SHALL hold stable while out_valid=1 and out_ready=0.
REQ-017 Single-cycle ops: request accepted at edge t SHALL appear with out_valid=1 after edge t+1 (one registered output stage).
REQ-018 in_ready SHALL equal (state==IDLE) && (!out_valid || out_ready); back-to-back single-cycle ops SHALL sustain one per cycle when out_ready=1.
REQ-019 Control FSM states: IDLE, MUL, DONE.
REQ-020 IDLE -> MUL on accepted MUL op; operands and tag latched; iteration counter loaded with WIDTH.
REQ-021 MUL: one shift-add step per cycle, counter decrements; at counter==1 -> DONE.
REQ-022 DONE: result loaded into output stage when output stage is empty or being drained this cycle, then -> IDLE; otherwise stay in DONE.
REQ-023 MUL with out_ready=1 SHALL give out_valid WIDTH+1 cycles after acceptance; in_ready=0 throughout MUL and DONE.
REQ-024 Responses SHALL leave in request order with their original tag; no response dropped or duplicated.

Reset
REQ-025 On rst_n=0, immediately: state=IDLE, counter=0, out_valid=0, out_y=0, all flags 0, out_err=0, out_tag=0; in_ready=0 while rst_n=0.
REQ-026 Reset mid-MUL SHALL abandon the operation with no response produced.
REQ-027 First request SHALL be acceptable on the first rising edge after rst_n deasserts.

Structure
REQ-028 Package alu_pipe_pkg SHALL hold the opcode enum (4-bit), FSM state enum, and opcode constants shared with the bench model.
REQ-029 The iterative multiplier SHALL be a sub-module alu_mul_iter (start, operands in; busy, done, product out); all else in alu_pipe.
REQ-030 The bench golden model SHALL be parametrised on WIDTH and reproduce REQ-009..015 exactly.

Verification (WIDTH=32, TAG_W=4)
REQ-031 ADD a=0xFFFFFFFF b=1 tag=3 -> next cycle y=0, Z=1, C=1, V=0, N=0, tag=3.
REQ-032 SUB a=0x80000000 b=1 -> y=0x7FFFFFFF, V=1, C=0, N=0; SUB a=0 b=1 -> y=0xFFFFFFFF, C=1, N=1.
REQ-033 SRA a=0x80000000 b=0x24 -> y=0xF8000000, N=1; op=0xF -> y=0, Z=1, out_err=1.
REQ-034 Hold out_ready=0, issue ADD tag=1 then AND tag=2 -> tag 1 held stable, in_ready=0, AND not accepted until drain; release -> tags 1,2 in order.
REQ-035 MUL a=7 b=6 with out_ready=1 -> in_ready=0 for 33 cycles, y=42 33 cycles after accept; MUL 0xFFFFFFFF*2 -> y=0xFFFFFFFE.
REQ-036 Assert rst_n=0 at cycle 10 of a MUL -> out_valid=0 immediately, no MUL response after release, next ADD 2+2 returns 4.

Source files
------------

// File: rtl/alu_pipe_pkg.sv
// Shared definitions for the ALU pipeline: opcode encoding and control FSM states.
// The opcode enum is also used by the testbench reference model.
package alu_pipe_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLT  = 4'd5,
        OP_SLTU = 4'd6,
        OP_SLL  = 4'd7,
        OP_SRL  = 4'd8,
        OP_SRA  = 4'd9,
        OP_MUL  = 4'd10
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_pipe_if.sv
// Request/response bus of the ALU pipeline; master drives requests, slave is the ALU.
interface alu_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic             out_z;
    logic             out_n;
    logic             out_c;
    logic             out_v;
    logic             out_err;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_y, out_z, out_n, out_c, out_v, out_err, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_y, out_z, out_n, out_c, out_v, out_err, out_tag
    );

endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles per product.
// Only the low WIDTH bits of the unsigned product are kept.
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= CNT_W'(WIDTH);
        end else if (busy) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Operand/accumulator registers are pure data; a cleared counter makes them don't-care.
    always_ff @(posedge clk) begin
        if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
        end else if (busy) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

    assign busy    = (cnt != '0);
    assign done    = (cnt == CNT_W'(1));
    assign product = acc;

endmodule

// File: rtl/alu_pipe.sv
// ALU with one registered output stage; single-cycle ops stream at one per cycle,
// MUL is handed to the iterative multiplier and blocks new requests until it retires.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_pipe_if.slave bus
);
    localparam int SH_W = $clog2(WIDTH);

    typedef struct packed {
        logic [WIDTH-1:0] y;
        logic             z;
        logic             n;
        logic             c;
        logic             v;
        logic             err;
    } res_t;

    function automatic res_t pack_res(input logic [WIDTH-1:0] y, input logic c,
                                      input logic v, input logic err);
        res_t r;
        r.y   = y;
        r.z   = (y == '0);
        r.n   = y[WIDTH-1];
        r.c   = c;
        r.v   = v;
        r.err = err;
        return r;
    endfunction

    function automatic res_t alu_eval(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                      input logic [WIDTH-1:0] b);
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        logic        [WIDTH:0]   sum;
        logic        [WIDTH-1:0] y;
        logic        [SH_W-1:0]  sh;
        logic                    c;
        logic                    v;
        logic                    err;
        sa  = a;
        sb  = b;
        sh  = b[SH_W-1:0];
        sum = '0;
        y   = '0;
        c   = 1'b0;
        v   = 1'b0;
        err = 1'b0;
        case (op)
            OP_ADD: begin
                sum = {1'b0, a} + {1'b0, b};
                y   = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = (a[WIDTH-1] == b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                y = a - b;
                c = (a < b);
                v = (a[WIDTH-1] != b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_SLT:  y = {{(WIDTH-1){1'b0}}, (sa < sb)};
            OP_SLTU: y = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL:  y = a << sh;
            OP_SRL:  y = a >> sh;
            OP_SRA:  y = sa >>> sh;
            // MUL never takes this path; it is retired from the iterative unit.
            default: err = 1'b1;
        endcase
        return pack_res(y, c, v, err);
    endfunction

    state_e           state;
    state_e           state_nxt;
    res_t             res_p0;
    res_t             res_mul;
    res_t             res_p1;
    logic [TAG_W-1:0] tag_mul;
    logic [TAG_W-1:0] tag_p1;
    logic             vld_p1;
    logic             drain_ok;
    logic             accept;
    logic             mul_start;
    logic             load_alu;
    logic             load_mul;
    logic             mul_busy;
    logic             mul_done;
    logic [WIDTH-1:0] product;

    assign drain_ok     = !vld_p1 || bus.out_ready;
    assign bus.in_ready = rst_n && (state == ST_IDLE) && drain_ok;
    assign accept       = bus.in_valid && bus.in_ready;

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (mul_start),
        .a      (bus.in_a),
        .b      (bus.in_b),
        .busy   (mul_busy),
        .done   (mul_done),
        .product(product)
    );

    always_comb begin
        state_nxt = state;
        mul_start = 1'b0;
        load_alu  = 1'b0;
        load_mul  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (bus.in_op == OP_MUL) begin
                        mul_start = 1'b1;
                        state_nxt = ST_MUL;
                    end else begin
                        load_alu = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (drain_ok && !mul_busy) begin
                    load_mul  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (mul_start) begin
            tag_mul <= bus.in_tag;
        end
    end

    // Stage p0 -> p1: combinational result into the single output register.
    assign res_p0  = alu_eval(bus.in_op, bus.in_a, bus.in_b);
    assign res_mul = pack_res(product, 1'b0, 1'b0, 1'b0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            res_p1 <= '0;
            tag_p1 <= '0;
        end else if (load_alu) begin
            vld_p1 <= 1'b1;
            res_p1 <= res_p0;
            tag_p1 <= bus.in_tag;
        end else if (load_mul) begin
            vld_p1 <= 1'b1;
            res_p1 <= res_mul;
            tag_p1 <= tag_mul;
        end else if (bus.out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign bus.out_valid = vld_p1;
    assign bus.out_y     = res_p1.y;
    assign bus.out_z     = res_p1.z;
    assign bus.out_n     = res_p1.n;
    assign bus.out_c     = res_p1.c;
    assign bus.out_v     = res_p1.v;
    assign bus.out_err   = res_p1.err;
    assign bus.out_tag   = tag_p1;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed corner cases plus randomized traffic scored against
// an arithmetic reference model and an in-order expected-response queue.
module tb_alu_pipe;
    import alu_pipe_pkg::*;

    localparam int W = 32;
    localparam int T = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(W), .TAG_W(T)) bus ();

    alu_pipe #(.WIDTH(W), .TAG_W(T)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    typedef struct {
        logic [W-1:0] y;
        logic [4:0]   f;   // {z, n, c, v, err}
        logic [T-1:0] tag;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t got_q[$];
    rsp_t held;
    bit   hold_pending  = 1'b0;
    bit   last_in_ready = 1'b0;
    bit   last_accept   = 1'b0;
    int   pops  = 0;
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Reference: results from plain arithmetic; carry/overflow from wrap-around tests.
    function automatic rsp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic [T-1:0] tag);
        rsp_t r;
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb;
        logic signed [W-1:0] sy;
        logic [W-1:0] mask;
        int   sh;
        logic c;
        logic v;
        logic err;
        sa   = a;
        sb   = b;
        mask = W'((1 << $clog2(W)) - 1);
        sh   = int'(b & mask);
        c    = 1'b0;
        v    = 1'b0;
        err  = 1'b0;
        r.y  = '0;
        case (op)
            OP_ADD: begin
                r.y = a + b;
                sy  = r.y;
                c   = (r.y < a);
                v   = (sb > 0 && sy < sa) || (sb < 0 && sy > sa);
            end
            OP_SUB: begin
                r.y = a - b;
                sy  = r.y;
                c   = (a < b);
                v   = (sb > 0 && sy > sa) || (sb < 0 && sy < sa);
            end
            OP_AND:  r.y = a & b;
            OP_OR:   r.y = a | b;
            OP_XOR:  r.y = a ^ b;
            OP_SLT:  r.y = (sa < sb) ? W'(1) : W'(0);
            OP_SLTU: r.y = (a < b) ? W'(1) : W'(0);
            OP_SLL:  r.y = a << sh;
            OP_SRL:  r.y = a >> sh;
            OP_SRA: begin
                r.y = a >> sh;
                if (a[W-1]) r.y = r.y | ~({W{1'b1}} >> sh);
            end
            OP_MUL:  r.y = a * b;
            default: err = 1'b1;
        endcase
        r.f   = {(r.y == '0), r.y[W-1], c, v, err};
        r.tag = tag;
        return r;
    endfunction

    function automatic rsp_t observe();
        rsp_t r;
        r.y   = bus.out_y;
        r.f   = {bus.out_z, bus.out_n, bus.out_c, bus.out_v, bus.out_err};
        r.tag = bus.out_tag;
        return r;
    endfunction

    // Drive one cycle at the falling edge, sample handshakes just after, then wait for the rising edge.
    task automatic cycle(input bit v, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [T-1:0] tag, input bit ordy);
        rsp_t cur;
        rsp_t e;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_op     = op;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_tag    = tag;
        bus.out_ready = ordy;
        #1;
        cur = observe();
        if (hold_pending) begin
            chk("hold_vld", bus.out_valid, 1'b1);
            chk("hold_y", cur.y, held.y);
            chk("hold_flags", cur.f, held.f);
            chk("hold_tag", cur.tag, held.tag);
        end
        hold_pending = 1'b0;
        if (bus.out_valid) begin
            if (ordy) begin
                pops++;
                got_q.push_back(cur);
                if (exp_q.size() == 0) begin
                    chk("spurious_vld", bus.out_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_y", cur.y, e.y);
                    chk("rsp_flags", cur.f, e.f);
                    chk("rsp_tag", cur.tag, e.tag);
                end
            end else begin
                hold_pending = 1'b1;
                held = cur;
            end
        end
        last_in_ready = bus.in_ready;
        last_accept   = v && bus.in_ready;
        if (last_accept) exp_q.push_back(model(op, a, b, tag));
        @(posedge clk);
    endtask

    task automatic idle(input bit ordy);
        cycle(1'b0, 4'd0, '0, '0, '0, ordy);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("rst_vld", bus.out_valid, 1'b0);
        chk("rst_y", bus.out_y, '0);
        chk("rst_flags", {bus.out_z, bus.out_n, bus.out_c, bus.out_v, bus.out_err}, '0);
        chk("rst_tag", bus.out_tag, '0);
        chk("rst_inrdy", bus.in_ready, 1'b0);
        exp_q.delete();
        hold_pending = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic chk_got(input string name, input int idx, input logic [W-1:0] y,
                           input logic [4:0] f, input logic [T-1:0] tag);
        if (idx < got_q.size()) begin
            chk({name, "_y"}, got_q[idx].y, y);
            chk({name, "_f"}, got_q[idx].f, f);
            chk({name, "_tag"}, got_q[idx].tag, tag);
        end else begin
            chk({name, "_missing"}, got_q.size(), idx + 1);
        end
    endtask

    task automatic wait_pop(output int lat, output int zeros);
        int p0;
        bit seen;
        lat   = -1;
        zeros = 0;
        seen  = 1'b0;
        for (int k = 1; k <= 200 && !seen; k++) begin
            p0 = pops;
            idle(1'b1);
            if (pops != p0) begin
                seen = 1'b1;
                lat  = k - 1;
            end else if (!last_in_ready) begin
                zeros++;
            end
        end
        chk("pop_seen", seen, 1'b1);
    endtask

    function automatic logic [W-1:0] rnd_opnd();
        logic [W-1:0] r;
        logic [63:0]  wide;
        wide = {$urandom(), $urandom()};
        case ($urandom_range(0, 5))
            0: r = '0;
            1: r = '1;
            2: begin
                r = '0;
                r[W-1] = 1'b1;
            end
            3: r = W'(1);
            default: r = wide[W-1:0];
        endcase
        return r;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int zeros;
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;

        do_reset();

        // ADD wrap-around, accepted on the first edge after reset release
        got_q.delete();
        cycle(1'b1, OP_ADD, 32'hFFFF_FFFF, 32'h1, 4'd3, 1'b1);
        chk("first_accept", last_accept, 1'b1);
        idle(1'b1);
        chk("add_lat_cnt", got_q.size(), 1);
        chk_got("add_wrap", 0, 32'h0, 5'b10100, 4'd3);

        got_q.delete();
        cycle(1'b1, OP_SUB, 32'h8000_0000, 32'h1, 4'd4, 1'b1);
        cycle(1'b1, OP_SUB, 32'h0, 32'h1, 4'd5, 1'b1);
        chk("b2b_accept", last_accept, 1'b1);
        idle(1'b1);
        chk_got("sub_ovf", 0, 32'h7FFF_FFFF, 5'b00010, 4'd4);
        chk_got("sub_borrow", 1, 32'hFFFF_FFFF, 5'b01100, 4'd5);

        got_q.delete();
        cycle(1'b1, OP_SRA, 32'h8000_0000, 32'h24, 4'd6, 1'b1);
        cycle(1'b1, 4'hF, 32'h1234_5678, 32'h9ABC_DEF0, 4'd7, 1'b1);
        idle(1'b1);
        chk_got("sra", 0, 32'hF800_0000, 5'b01000, 4'd6);
        chk_got("illegal", 1, 32'h0, 5'b10001, 4'd7);

        // Backpressure: second request must wait until the first drains
        got_q.delete();
        cycle(1'b1, OP_ADD, 32'h10, 32'h20, 4'd1, 1'b0);
        chk("bp_first_acc", last_accept, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, OP_AND, 32'hF0, 32'h3C, 4'd2, 1'b0);
            chk("bp_inrdy", last_in_ready, 1'b0);
        end
        chk("bp_no_pop", got_q.size(), 0);
        cycle(1'b1, OP_AND, 32'hF0, 32'h3C, 4'd2, 1'b1);
        chk("bp_drain_acc", last_accept, 1'b1);
        idle(1'b1);
        chk_got("bp_rsp0", 0, 32'h30, 5'b00000, 4'd1);
        chk_got("bp_rsp1", 1, 32'h30, 5'b00000, 4'd2);

        // Iterative multiply latency and blocking
        got_q.delete();
        cycle(1'b1, OP_MUL, 32'd7, 32'd6, 4'd8, 1'b1);
        chk("mul_accept", last_accept, 1'b1);
        wait_pop(lat, zeros);
        chk("mul_lat", lat, W + 1);
        chk("mul_busy_cycles", zeros, W + 1);
        chk_got("mul_7x6", 0, 32'd42, 5'b00000, 4'd8);

        got_q.delete();
        cycle(1'b1, OP_MUL, 32'hFFFF_FFFF, 32'd2, 4'd9, 1'b1);
        wait_pop(lat, zeros);
        chk_got("mul_wrap", 0, 32'hFFFF_FFFE, 5'b01000, 4'd9);

        // Reset must clear a held response at once
        cycle(1'b1, OP_OR, 32'h5, 32'hA, 4'd12, 1'b0);
        idle(1'b0);
        do_reset();

        // Reset part-way through a multiply abandons it
        cycle(1'b1, OP_MUL, 32'd3, 32'd5, 4'd10, 1'b1);
        repeat (10) idle(1'b1);
        do_reset();
        got_q.delete();
        repeat (60) idle(1'b1);
        chk("no_mul_after_rst", got_q.size(), 0);
        cycle(1'b1, OP_ADD, 32'd2, 32'd2, 4'd11, 1'b1);
        chk("post_rst_accept", last_accept, 1'b1);
        idle(1'b1);
        chk_got("post_rst_add", 0, 32'd4, 5'b00000, 4'd11);

        // Randomized traffic with random backpressure
        for (int i = 0; i < 600; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 15));
            if (op == OP_MUL && $urandom_range(0, 3) != 0) op = OP_XOR;
            cycle($urandom_range(0, 3) != 0, op, rnd_opnd(), rnd_opnd(), T'($urandom()),
                  $urandom_range(0, 9) < 7);
        end
        for (int i = 0; i < 300 && exp_q.size() > 0; i++) idle(1'b1);
        chk("drain_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
